// File: rtl/iir_biquad_mac_seq.sv
// Direct-Form-I biquad sequencer. Time-multiplexes one external signed MAC
// (c = a*b + din) over five taps per sample and returns a saturated output.
module iir_biquad_mac_seq #(
  parameter int A_WIDTH = 7,
  parameter int B_WIDTH = 6,
  parameter int FRAC    = 5
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic signed [A_WIDTH-1:0]            b0,
  input  logic signed [A_WIDTH-1:0]            b1,
  input  logic signed [A_WIDTH-1:0]            b2,
  input  logic signed [A_WIDTH-1:0]            a1n,
  input  logic signed [A_WIDTH-1:0]            a2n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic signed [B_WIDTH-1:0]            x_in,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic signed [B_WIDTH-1:0]            y_out,
  output logic signed [A_WIDTH-1:0]            mac_a,
  output logic signed [B_WIDTH-1:0]            mac_b,
  output logic signed [A_WIDTH+B_WIDTH-1:0]    mac_din,
  input  logic signed [A_WIDTH+B_WIDTH-1:0]    mac_c
);

  localparam int AW = A_WIDTH + B_WIDTH;

  // Saturation bounds expressed at accumulator width so the compare is signed.
  localparam logic signed [AW-1:0] Y_MAX = AW'((2 ** (B_WIDTH - 1)) - 1);
  localparam logic signed [AW-1:0] Y_MIN = ~Y_MAX;

  typedef enum logic [1:0] {IDLE, TAP, OUT} state_t;

  state_t                     state;
  logic [2:0]                 tap;
  logic signed [AW-1:0]       acc;
  logic signed [B_WIDTH-1:0]  x0, x1, x2, y1, y2;
  logic signed [AW-1:0]       y_shift;
  logic signed [B_WIDTH-1:0]  y_sat;

  // Route the current tap's coefficient and sample to the MAC; idle outside TAP.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    mac_a   = '0;
    mac_b   = '0;
    mac_din = '0;
    if (state == TAP) begin
      mac_din = acc;
      case (tap)
        3'd0:    begin mac_a = b0;  mac_b = x0; end
        3'd1:    begin mac_a = b1;  mac_b = x1; end
        3'd2:    begin mac_a = b2;  mac_b = x2; end
        3'd3:    begin mac_a = a1n; mac_b = y1; end
        3'd4:    begin mac_a = a2n; mac_b = y2; end
        default: begin mac_a = '0;  mac_b = '0; end
      endcase
    end
  end

  // Scale the final accumulation back to sample format (floor) and clamp it.
  always_comb begin
    y_shift = mac_c >>> FRAC;
    if (y_shift > Y_MAX) begin
      y_sat = Y_MAX[B_WIDTH-1:0];
    end else if (y_shift < Y_MIN) begin
      y_sat = Y_MIN[B_WIDTH-1:0];
    end else begin
      y_sat = y_shift[B_WIDTH-1:0];
    end
  end

  // Sequencer: accept a sample, run five MAC taps, present the result, shift history.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      y_out     <= '0;
      acc       <= '0;
      tap       <= '0;
      x0        <= '0;
      x1        <= '0;
      x2        <= '0;
      y1        <= '0;
      y2        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x0       <= x_in;
            acc      <= '0;
            tap      <= '0;
            in_ready <= 1'b0;
            state    <= TAP;
          end
        end
        TAP: begin
          acc <= mac_c;
          tap <= tap + 3'd1;
          if (tap == 3'd4) begin
            y_out     <= y_sat;
            out_valid <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            x2        <= x1;
            x1        <= x0;
            y2        <= y1;
            y1        <= y_out;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iir_biquad_mac_seq.sv
// Bench for the biquad MAC sequencer: directed cases plus random traffic,
// scored against a plain-arithmetic DF-I reference model.
module tb_iir_biquad_mac_seq;

  logic              clk = 1'b0;
  logic              reset;
  logic signed [6:0] b0, b1, b2, a1n, a2n;
  logic              in_valid;
  logic              in_ready;
  logic signed [5:0] x_in;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic signed [5:0] y_out;
  logic signed [6:0] mac_a;
  logic signed [5:0] mac_b;
  logic signed [12:0] mac_din;
  logic signed [12:0] mac_c;

  // Behavioural stand-in for the signed MAC that sits beside the sequencer.
  logic signed [12:0] ma, mb;
  assign ma    = 13'(mac_a);
  assign mb    = 13'(mac_b);
  assign mac_c = ma * mb + mac_din;

  iir_biquad_mac_seq dut (
    .clk(clk), .reset(reset),
    .b0(b0), .b1(b1), .b2(b2), .a1n(a1n), .a2n(a2n),
    .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
    .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out),
    .mac_a(mac_a), .mac_b(mac_b), .mac_din(mac_din), .mac_c(mac_c)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int lat_q[$];
  bit stall = 1'b0;
  bit rand_mode = 1'b0;
  int hx1, hx2, hy1, hy2;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: full-precision sum of the five products, wrapped to 13 bits,
  // floor-divided by 32, clamped to the 6-bit signed range; then history shifts.
  function automatic int model_step(input int x);
    int s, y;
    s = int'(b0) * x + int'(b1) * hx1 + int'(b2) * hx2 + int'(a1n) * hy1 + int'(a2n) * hy2;
    s = s & 8191;
    if (s >= 4096) s = s - 8192;
    y = s >>> 5;
    if (y > 31) y = 31;
    if (y < -32) y = -32;
    hx2 = hx1; hx1 = x; hy2 = hy1; hy1 = y;
    return y;
  endfunction

  // Consumer and monitor: choose out_ready for the coming edge, then score outputs.
  bit prev_ov = 1'b0;
  bit prev_or = 1'b0;
  logic signed [5:0] prev_y = '0;
  always @(negedge clk) begin
    out_ready = stall ? 1'b0 : (rand_mode ? 1'($urandom_range(0, 1)) : 1'b1);
    if (reset !== 1'b0) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid === 1'b1) check("in_ready_low_while_out_valid", int'(in_ready), 0);
      if (in_ready === 1'b1 || out_valid === 1'b1) begin
        check("mac_a_idle_zero", int'(mac_a), 0);
        check("mac_b_idle_zero", int'(mac_b), 0);
        check("mac_din_idle_zero", int'(mac_din), 0);
      end
      if (prev_ov && !prev_or) begin
        check("out_valid_held", int'(out_valid), 1);
        check("y_out_held", int'(y_out), int'(prev_y));
      end
      if (out_valid === 1'b1 && !prev_ov) begin
        if (lat_q.size() == 0) check("unexpected_out_valid", 1, 0);
        else check("latency", cyc - lat_q.pop_front(), 6);
      end
      if (out_valid === 1'b1 && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_output", int'(y_out), 9999);
        else check("y_out", int'(y_out), exp_q.pop_front());
      end
      prev_ov = (out_valid === 1'b1);
      prev_or = out_ready;
      prev_y  = y_out;
    end
  end

  // Assert reset for one edge (caller is at a negedge), check reset state, clear the model.
  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_y_out", int'(y_out), 0);
    check("rst_mac_a", int'(mac_a), 0);
    check("rst_mac_din", int'(mac_din), 0);
    reset = 1'b0;
    exp_q.delete();
    lat_q.delete();
    hx1 = 0; hx2 = 0; hy1 = 0; hy2 = 0;
  endtask

  // Wait for the block to be idle, load coefficients, present one sample for one accept.
  task automatic send(input logic signed [5:0] x, input logic signed [6:0] c0,
                      input logic signed [6:0] c1, input logic signed [6:0] c2,
                      input logic signed [6:0] c3, input logic signed [6:0] c4);
    int n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      check("in_ready_timeout", int'(in_ready), 1);
    end else begin
      b0 = c0; b1 = c1; b2 = c2; a1n = c3; a2n = c4;
      in_valid = 1'b1;
      x_in = x;
      exp_q.push_back(model_step(int'(x)));
      lat_q.push_back(cyc);
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    int n;
    reset = 1'b1; in_valid = 1'b0; x_in = '0;
    b0 = '0; b1 = '0; b2 = '0; a1n = '0; a2n = '0;
    @(negedge clk);
    do_reset();

    // Unity gain, two samples.
    send(6'sd10, 7'sd32, 7'sd0, 7'sd0, 7'sd0, 7'sd0);
    send(-6'sd7, 7'sd32, 7'sd0, 7'sd0, 7'sd0, 7'sd0);
    drain();

    // Halving feedback: decaying impulse response with floor.
    do_reset();
    send(6'sd20, 7'sd32, 7'sd0, 7'sd0, 7'sd16, 7'sd0);
    for (int i = 0; i < 5; i++) send(6'sd0, 7'sd32, 7'sd0, 7'sd0, 7'sd16, 7'sd0);
    drain();

    // Saturation at both rails.
    do_reset();
    send(6'sd31, 7'sd63, 7'sd63, 7'sd0, 7'sd0, 7'sd0);
    send(6'sd31, 7'sd63, 7'sd63, 7'sd0, 7'sd0, 7'sd0);
    send(-6'sd32, 7'sd63, 7'sd63, 7'sd0, 7'sd0, 7'sd0);
    send(-6'sd32, 7'sd63, 7'sd63, 7'sd0, 7'sd0, 7'sd0);
    drain();

    // Output back-pressure with ignored in_valid pulses.
    do_reset();
    send(6'sd3, 7'sd32, 7'sd0, 7'sd0, 7'sd0, 7'sd0);
    stall = 1'b1;
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("stall_out_valid_seen", int'(out_valid), 1);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      x_in = 6'sd25;
      @(negedge clk);
      check("stall_in_ready_low", int'(in_ready), 0);
      in_valid = 1'b0;
    end
    stall = 1'b0;
    send(6'sd4, 7'sd32, 7'sd16, 7'sd0, 7'sd0, 7'sd0);
    drain();

    // Reset in the middle of tap2, then history must be clear.
    send(6'sd9, 7'sd32, 7'sd0, 7'sd0, 7'sd0, 7'sd0);
    @(negedge clk);
    @(negedge clk);
    do_reset();
    send(6'sd5, 7'sd32, 7'sd0, 7'sd0, 7'sd0, 7'sd0);
    drain();

    // Random coefficients, samples, gaps and consumer back-pressure.
    do_reset();
    rand_mode = 1'b1;
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(6'($urandom), 7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom));
    end
    drain();
    rand_mode = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
